// File: rtl/snake_grid_map.sv
// Occupancy bitmap for the snake body: head writes set cells, tail clears vacate them.
// Provides a registered cell-query port, a running occupied-cell count and a sticky self-collision flag.
module snake_grid_map #(
  parameter int                         H_LOGIC_WIDTH = 5,
  parameter int                         V_LOGIC_WIDTH = 5,
  parameter logic [H_LOGIC_WIDTH-1:0]   H_LOGIC_MAX   = 5'd31,
  parameter logic [V_LOGIC_WIDTH-1:0]   V_LOGIC_MAX   = 5'd23,
  parameter int                         CNT_WIDTH     = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  output logic                     busy,
  input  logic                     head_wren,
  input  logic [H_LOGIC_WIDTH-1:0] headx,
  input  logic [V_LOGIC_WIDTH-1:0] heady,
  input  logic                     tail_clren,
  input  logic [H_LOGIC_WIDTH-1:0] tailx,
  input  logic [V_LOGIC_WIDTH-1:0] taily,
  input  logic [H_LOGIC_WIDTH-1:0] qx,
  input  logic [V_LOGIC_WIDTH-1:0] qy,
  output logic                     qhit,
  output logic                     collide,
  output logic [CNT_WIDTH-1:0]     occ_cnt
);

  localparam int COLS = int'(H_LOGIC_MAX) + 1;
  localparam int ROWS = int'(V_LOGIC_MAX) + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;
  logic [V_LOGIC_WIDTH-1:0] r_row_idx;
  logic [COLS-1:0]          r_map [ROWS];
  logic                     r_qhit;
  logic                     r_collide;
  logic [CNT_WIDTH-1:0]     r_occ_cnt;

  logic w_upd_en;
  logic w_tail_in;
  logic w_head_in;
  logic w_q_in;
  logic w_same;
  logic w_tail_hit;
  logic w_head_occ;
  logic w_head_set;
  logic w_head_col;

  // Widened compare so the x bound stays meaningful when H_LOGIC_MAX fills the field.
  function automatic logic in_range(input logic [H_LOGIC_WIDTH-1:0] x,
                                    input logic [V_LOGIC_WIDTH-1:0] y);
    return (32'(x) <= 32'(H_LOGIC_MAX)) && (32'(y) <= 32'(V_LOGIC_MAX));
  endfunction

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (clr) w_next_state = CLEAR;
      CLEAR: begin
        if (clr)                           w_next_state = CLEAR;
        else if (r_row_idx == V_LOGIC_MAX) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Tail clear is resolved before the head set, so a head landing on the cell
  // the tail vacates in the same cycle sees it empty.
  always_comb begin
    w_upd_en   = (r_state == IDLE) && !clr;
    w_tail_in  = w_upd_en && tail_clren && in_range(tailx, taily);
    w_head_in  = w_upd_en && head_wren && in_range(headx, heady);
    w_q_in     = in_range(qx, qy);
    w_same     = (headx == tailx) && (heady == taily);
    w_tail_hit = 1'b0;
    if (w_tail_in) w_tail_hit = r_map[taily][tailx];
    w_head_occ = 1'b0;
    if (w_head_in) w_head_occ = r_map[heady][headx] && !(w_tail_hit && w_same);
    w_head_set = w_head_in && !w_head_occ;
    w_head_col = w_head_in && w_head_occ;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_idx <= '0;
      r_qhit    <= 1'b0;
      r_collide <= 1'b0;
      r_occ_cnt <= '0;
      for (int i = 0; i < ROWS; i++) r_map[i] <= '0;
    end else begin
      // Query reads the map as it stood before this edge's updates.
      r_qhit <= (r_state == IDLE) && !clr && w_q_in && r_map[qy][qx];
      case (r_state)
        IDLE: begin
          if (clr) begin
            r_row_idx <= '0;
            r_occ_cnt <= '0;
            r_collide <= 1'b0;
          end else begin
            if (w_tail_hit) r_map[taily][tailx] <= 1'b0;
            if (w_head_set) r_map[heady][headx] <= 1'b1;
            r_occ_cnt <= r_occ_cnt + CNT_WIDTH'(w_head_set) - CNT_WIDTH'(w_tail_hit);
            if (w_head_col) r_collide <= 1'b1;
          end
        end
        CLEAR: begin
          r_map[r_row_idx] <= '0;
          r_occ_cnt        <= '0;
          r_collide        <= 1'b0;
          if (clr) r_row_idx <= '0;
          else     r_row_idx <= r_row_idx + 1'b1;
        end
        default: r_row_idx <= '0;
      endcase
    end
  end

  assign busy    = (r_state == CLEAR);
  assign qhit    = r_qhit;
  assign collide = r_collide;
  assign occ_cnt = r_occ_cnt;

endmodule
